// File: rtl/bus_cycle_ctrl.sv
// bus_cycle_ctrl
//   Runs one 68000-style asynchronous bus cycle for each request from the
//   core's memory-access unit. Sequence: IDLE -> ADDR -> STRB -> WAIT -> TERM.
//   The cycle ends on a synchronised dtack_n or on berr_n from the bus
//   watchdog. wd_clr pulses in ADDR (cycle start) and in TERM (cycle end).
//
// Handshake (req/ready): a request is accepted on a rising clk edge where
//   req=1 and ready=1. addr/wdata/rw/be are captured on that edge. A req
//   seen while ready=0 is dropped, not queued. Every accepted cycle ends with
//   exactly one done pulse, and bus_err/rdata are valid with it. The one
//   exception is a reset, which aborts the cycle with no done pulse.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req, rw, be, addr,     request side: rw 1=read; be={upper,lower} lanes,
//   wdata                  2'b00 means both lanes
//   ready, done, bus_err,  core side status; rdata holds until the next
//   rdata                  completed read
//   a_o, d_o, d_oe, d_i    address / data pins
//   as_n, uds_n, lds_n,    bus strobes and direction (rw_n 1=read)
//   rw_n
//   dtack_n                asynchronous acknowledge, active-low
//   berr_n                 watchdog bus error, active-low, clk-synchronous
//   wd_clr                 watchdog clear pulse
//   dbg_state              current FSM state (0 IDLE,1 ADDR,2 STRB,3 WAIT,4 TERM)
module bus_cycle_ctrl #(
  parameter int ADDR_W   = 23,
  parameter int DATA_W   = 16,
  parameter int MIN_WAIT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              rw,
  input  logic [1:0]        be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              bus_err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] a_o,
  output logic [DATA_W-1:0] d_o,
  output logic              d_oe,
  input  logic [DATA_W-1:0] d_i,
  output logic              as_n,
  output logic              uds_n,
  output logic              lds_n,
  output logic              rw_n,
  input  logic              dtack_n,
  input  logic              berr_n,
  output logic              wd_clr,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    STRB = 3'd2,
    WAIT = 3'd3,
    TERM = 3'd4
  } state_t;

  localparam int         HALF       = DATA_W / 2;
  localparam logic [3:0] MIN_WAIT_C = 4'(MIN_WAIT);

  state_t      state_q, state_d;
  logic        rw_q;
  logic [1:0]  be_q;
  logic        err_q;
  logic [3:0]  cnt_q;
  logic        stale_q;     // dtack was still low when the previous cycle ended
  logic        dtack_m, dtack_s;
  logic        berr_q;
  logic        accept;
  logic        term_ok, term_err;
  logic        strobe_on;
  logic [DATA_W-1:0] lane_mask;

  assign accept    = (state_q == IDLE) && req;
  assign lane_mask = {{HALF{be_q[1]}}, {HALF{be_q[0]}}};
  assign dbg_state = state_q;

  // Next-state logic. berr wins over dtack and may end the cycle at any WAIT
  // cycle. dtack is honoured only once the wait counter has reached MIN_WAIT
  // and any stale acknowledge left over from the previous cycle has been
  // absorbed by one extra WAIT cycle.
  always_comb begin
    state_d  = state_q;
    term_ok  = 1'b0;
    term_err = 1'b0;
    case (state_q)
      IDLE: if (req) state_d = ADDR;
      ADDR: state_d = STRB;
      STRB: state_d = WAIT;
      WAIT: begin
        if (!berr_q) begin
          state_d  = TERM;
          term_err = 1'b1;
        end else if ((cnt_q == MIN_WAIT_C) && !stale_q && !dtack_s) begin
          state_d = TERM;
          term_ok = 1'b1;
        end
      end
      TERM:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin and status decode from the registered state.
  always_comb begin
    ready     = (state_q == IDLE);
    done      = (state_q == TERM);
    bus_err   = (state_q == TERM) && err_q;
    wd_clr    = (state_q == ADDR) || (state_q == TERM);
    as_n      = !((state_q == STRB) || (state_q == WAIT));
    rw_n      = (state_q == IDLE) ? 1'b1 : rw_q;
    d_oe      = !rw_q && (state_q != IDLE);
    // Read strobes open with as_n. Write strobes wait one cycle so the data
    // is set up before they fall.
    strobe_on = (state_q == WAIT) || ((state_q == STRB) && rw_q);
    uds_n     = !(strobe_on && be_q[1]);
    lds_n     = !(strobe_on && be_q[0]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rw_q    <= 1'b1;
      be_q    <= 2'b11;
      a_o     <= '0;
      d_o     <= '0;
      rdata   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
      dtack_m <= 1'b1;
      dtack_s <= 1'b1;
      berr_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      dtack_m <= dtack_n;
      dtack_s <= dtack_m;
      berr_q  <= berr_n;

      if (accept) begin
        a_o  <= addr;
        d_o  <= wdata;
        rw_q <= rw;
        be_q <= (be == 2'b00) ? 2'b11 : be;
      end

      if (state_q == STRB) begin
        cnt_q <= '0;
      end else if (state_q == WAIT) begin
        if (cnt_q != MIN_WAIT_C) cnt_q <= cnt_q + 4'd1;
        else                     stale_q <= 1'b0;
      end

      if (state_q == TERM) stale_q <= !dtack_s;

      if (term_ok || term_err) err_q <= term_err;
      if (term_ok && rw_q)     rdata <= d_i & lane_mask;
    end
  end

endmodule
